// File: rtl/cla_pkg.sv
// cla_pkg: shared group width, 4-bit slice type and group-count helper for the pipelined CLA adder
package cla_pkg;
    localparam int CLA_GRP_W = 4;
    typedef logic [CLA_GRP_W-1:0] cla_grp_t;
    function automatic int cla_ngrp(input int width);
        return width / CLA_GRP_W;
    endfunction
endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group
//   a, b    : operand slices
//   c_in    : carry into the group
//   s       : sum slice
//   c_out   : carry out of the group
//   p_grp   : group propagate (for a future second lookahead level)
//   g_grp   : group generate  (for a future second lookahead level)
module cla_group4
    import cla_pkg::*;
(
    input  cla_grp_t a,
    input  cla_grp_t b,
    input  logic     c_in,
    output cla_grp_t s,
    output logic     c_out,
    output logic     p_grp,
    output logic     g_grp
);
    cla_grp_t p, g, c;
    assign p = a ^ b;
    assign g = a & b;
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    assign p_grp = &p;
    assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign c_out = g_grp | (p_grp & c_in);
    assign s = p ^ c;
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, one 4-bit group resolved per stage
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake
//   a, b, c_in, sub      : operands; sub=1 computes a - b (carry in c_in ^ 1)
//   out_valid / out_ready: result handshake
//   s, c_out             : sum mod 2^WIDTH and carry out of the MSB (for sub: 1 = no borrow)
//   ovf                  : signed overflow, present only when CLA_PIPE_OVF_EN is defined
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef CLA_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             c_out
);
    localparam int NGRP = cla_ngrp(WIDTH);
    if (WIDTH % CLA_GRP_W != 0 || WIDTH < CLA_GRP_W) begin : g_chk
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 and at least 4");
    end
    logic             advance;
    logic [WIDTH-1:0] bx;
    logic             cx;
    // The whole pipe moves together; a held result freezes every stage behind it.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign bx = sub ? ~b : b;
    assign cx = c_in ^ sub;
    for (genvar k = 0; k < NGRP; k++) begin : g_st
        // Group k feeds stage register k+1; rw = operand bits still unresolved entering group k.
        localparam int RW = WIDTH - CLA_GRP_W * k;
        localparam int SW = CLA_GRP_W * (k + 1);
        logic          v_i, c_i, v_r, c_r, gco, gp, gg, unused_pg;
        logic [RW-1:0] a_i, b_i;
        logic [SW-1:0] s_d, s_r;
        cla_grp_t      gs;
        if (k == 0) begin : g_src
            assign v_i = in_valid;
            assign a_i = a;
            assign b_i = bx;
            assign c_i = cx;
            assign s_d = gs;
        end else begin : g_src
            assign v_i = g_st[k-1].v_r;
            assign a_i = g_st[k-1].g_op.a_r;
            assign b_i = g_st[k-1].g_op.b_r;
            assign c_i = g_st[k-1].c_r;
            assign s_d = {gs, g_st[k-1].s_r};
        end
        cla_group4 u_grp (
            .a     (a_i[CLA_GRP_W-1:0]),
            .b     (b_i[CLA_GRP_W-1:0]),
            .c_in  (c_i),
            .s     (gs),
            .c_out (gco),
            .p_grp (gp),
            .g_grp (gg)
        );
        assign unused_pg = gp ^ gg;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                v_r <= 1'b0;
                s_r <= '0;
                c_r <= 1'b0;
            end else if (advance) begin
                v_r <= v_i;
                s_r <= s_d;
                c_r <= gco;
            end
        if (k < NGRP - 1) begin : g_op
            logic [RW-CLA_GRP_W-1:0] a_r, b_r;
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (advance) begin
                    a_r <= a_i[RW-1:CLA_GRP_W];
                    b_r <= b_i[RW-1:CLA_GRP_W];
                end
        end
`ifdef CLA_PIPE_OVF_EN
        if (k == NGRP - 1) begin : g_ovf
            logic ovf_r;
            // Carry into the MSB is recovered as p ^ s of the top bit.
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n)
                    ovf_r <= 1'b0;
                else if (advance)
                    ovf_r <= gco ^ (a_i[CLA_GRP_W-1] ^ b_i[CLA_GRP_W-1] ^ gs[CLA_GRP_W-1]);
        end
`endif
    end
    assign out_valid = g_st[NGRP-1].v_r;
    assign s         = g_st[NGRP-1].s_r;
    assign c_out     = g_st[NGRP-1].c_r;
`ifdef CLA_PIPE_OVF_EN
    assign ovf = g_st[NGRP-1].g_ovf.ovf_r;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed self-checking bench for the 16-bit pipelined CLA adder
module tb_cla_pipe_adder;
    localparam int W = 16;
    localparam int NGRP = 4;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         c_in = 1'b0, sub = 1'b0;
    logic         out_valid, out_ready = 1'b0;
    logic [W-1:0] s;
    logic         c_out;
`ifdef CLA_PIPE_OVF_EN
    logic         ovf;
`endif
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
`ifdef CLA_PIPE_OVF_EN
        .ovf       (ovf),
`endif
        .c_out     (c_out)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask
    // Issue one op into an idle pipe, measure latency and check the result.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic tsub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a = ta; b = tb; c_in = tc; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, NGRP);
        check({tag, "_s"}, s, es);
        check({tag, "_c"}, c_out, ec);
`ifdef CLA_PIPE_OVF_EN
        check({tag, "_ovf"}, ovf, eo);
`else
        if (eo === 1'bz) $display("note: %s ovf expectation unused", tag);
`endif
    endtask
    logic [W-1:0] sa [8] = '{16'h0001, 16'h00FF, 16'hFFFF, 16'h1000, 16'h0000, 16'h0F0F, 16'h2222, 16'h8001};
    logic [W-1:0] sb [8] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 16'hF0F0, 16'h1111, 16'h8000};
    logic         sc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic         su [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] ss [8] = '{16'h0002, 16'h0100, 16'hFFFE, 16'h0FFF, 16'hFFFF, 16'h0000, 16'h3333, 16'h0001};
    logic         sco[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    initial begin
        int tx, rx;
        bit held, seen;
        logic [W-1:0] hs;
        logic hc;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_c", c_out, 0);
        check("rst_ready", in_ready, 1);
`ifdef CLA_PIPE_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub_neg",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_pos",16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("ovf_add",16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_sub",16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("cin_add",16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        run_op("cin_sub",16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
        run_op("carry16",16'hABCD, 16'h5433, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("negneg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        // Back-to-back stream with a three-cycle output stall in the middle.
        tx = 0; rx = 0; held = 0; hs = '0; hc = 1'b0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (tx < 8) begin
                in_valid = 1'b1; a = sa[tx]; b = sb[tx]; c_in = sc[tx]; sub = su[tx];
            end else in_valid = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                check("stall_ready", in_ready, 0);
                if (held) begin
                    check("hold_s", s, hs);
                    check("hold_c", c_out, hc);
                end
                hs = s; hc = c_out; held = 1;
            end
            if (out_valid && out_ready) begin
                check($sformatf("strm%0d_s", rx), s, ss[rx]);
                check($sformatf("strm%0d_c", rx), c_out, sco[rx]);
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        check("strm_count", rx, 8);
        check("strm_held", held, 1);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("strm_nodup", seen, 0);
        // Reset with three ops in flight, the oldest already presented.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; c_in = 1'b0; sub = 1'b0;
            a = 16'h0101 + 16'(i); b = 16'h0202;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_s", s, 16'h0303);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_s", s, 0);
        check("async_c", c_out, 0);
        check("async_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("no_stale", seen, 0);
        run_op("post_rst", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
